// File: rtl/subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: state encoding, default width
// and the bit-counter sizing helper.
package subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Counter width that can index bits 0..w-1 (never below one bit).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor; master issues operations,
// slave (the subtractor) computes them.
interface serial_subtractor_if
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  ready, busy, done, d, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, d, bout, ovf
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: x - y - bi.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);
    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin: one full-subtractor cell, LSB first, WIDTH cycles per
// operation; results are published together with a one-cycle done pulse.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic             borrow_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic [WIDTH-1:0] d_reg;
    logic             bout_reg;
    logic             ovf_reg;
    logic             done_reg;
    logic             cell_diff;
    logic             cell_bo;
    logic             last_bit;

    assign last_bit = (cnt_reg == LAST_BIT);

    full_subtractor u_cell (
        .x    (a_sh_reg[0]),
        .y    (b_sh_reg[0]),
        .bi   (borrow_reg),
        .diff (cell_diff),
        .bo   (cell_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state_reg == IDLE);
        bus.busy  = (state_reg == SHIFT);
    end

    assign bus.done = done_reg;
    assign bus.d    = d_reg;
    assign bus.bout = bout_reg;
    assign bus.ovf  = ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            d_reg      <= '0;
            bout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            // Registered so the pulse lines up with the freshly published result.
            done_reg <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_reg   <= bus.a;
                        b_sh_reg   <= bus.b;
                        borrow_reg <= bus.bin;
                        a_msb_reg  <= bus.a[WIDTH-1];
                        b_msb_reg  <= bus.b[WIDTH-1];
                        cnt_reg    <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    res_reg    <= {cell_diff, res_reg[WIDTH-1:1]};
                    borrow_reg <= cell_bo;
                    if (!last_bit) cnt_reg <= cnt_reg + CNT_W'(1);
                end
                DONE: begin
                    // Operand MSBs were kept aside because the shifters discard them.
                    d_reg    <= res_reg;
                    bout_reg <= borrow_reg;
                    ovf_reg  <= (a_msb_reg ^ b_msb_reg) & (res_reg[WIDTH-1] ^ a_msb_reg);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases, ignored
// starts, asynchronous reset abort and a randomized run against an arithmetic model.
module tb_serial_subtractor;
    import subtractor_pkg::*;

    localparam int W   = 8;
    localparam int LAT = W + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] dir_a    [4] = '{8'h05, 8'h00, 8'h80, 8'h10};
    logic [W-1:0] dir_b    [4] = '{8'h03, 8'h01, 8'h01, 8'h0F};
    logic         dir_bin  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] dir_d    [4] = '{8'h02, 8'hFF, 8'h7F, 8'h00};
    logic         dir_bout [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         dir_ovf  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Reference: plain integer arithmetic, unsigned for d/bout, signed range for ovf.
    function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic bin, output logic [W-1:0] d,
                                    output logic bout, output logic ovf);
        int u;
        int s;
        u    = int'(a) - int'(b) - int'(bin);
        s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d    = u[W-1:0];
        bout = (u < 0);
        ovf  = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    // Issues one operation from a negedge and returns at the negedge where done is seen.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input bit scramble, input int inject,
                         output int lat, output logic [W-1:0] od, output logic obout,
                         output logic oovf, output int hold_bad);
        logic [W-1:0] prev_d;
        logic         prev_bout;
        logic         prev_ovf;
        prev_d    = bus.d;
        prev_bout = bus.bout;
        prev_ovf  = bus.ovf;
        hold_bad  = 0;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 4 * LAT) begin
            if (bus.d !== prev_d || bus.bout !== prev_bout || bus.ovf !== prev_ovf)
                hold_bad++;
            if (scramble) begin
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.bin   = 1'($urandom);
                bus.start = (bus.ready === 1'b0) ? 1'($urandom) : 1'b0;
            end
            if (inject != 0 && lat == inject) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'h00;
                bus.bin   = 1'b1;
            end else if (inject != 0 && lat == inject + 1) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        od    = bus.d;
        obout = bus.bout;
        oovf  = bus.ovf;
        $display("op a=%02h b=%02h bin=%0d -> d=%02h bout=%0d ovf=%0d lat=%0d",
                 a, b, bin, od, obout, oovf, lat);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            checks++;
            if ({bus.ready, bus.busy, bus.done, bus.bout, bus.ovf} !== 5'b10000) begin
                failures++;
                $display("FAIL reset_flags: got rdy/busy/done/bout/ovf=%05b expected 10000",
                         {bus.ready, bus.busy, bus.done, bus.bout, bus.ovf});
            end
            checks++;
            if (bus.d !== 8'h00) begin
                failures++;
                $display("FAIL reset_d: got %02h expected 00", bus.d);
            end
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got ready=%0d busy=%0d expected 1 0", bus.ready, bus.busy);
        end
        $display("reset sequence complete");
    endtask

    task automatic test_directed();
        int lat;
        int hold_bad;
        logic [W-1:0] od;
        logic ob;
        logic ov;
        for (int i = 0; i < 4; i++) begin
            do_op(dir_a[i], dir_b[i], dir_bin[i], 1'b0, 0, lat, od, ob, ov, hold_bad);
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT);
            end
            checks++;
            if (od !== dir_d[i] || ob !== dir_bout[i] || ov !== dir_ovf[i]) begin
                failures++;
                $display("FAIL dir%0d_result: got d=%02h bout=%0d ovf=%0d expected d=%02h bout=%0d ovf=%0d",
                         i, od, ob, ov, dir_d[i], dir_bout[i], dir_ovf[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_done_width: got done=%0d expected 0", i, bus.done);
            end
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        int hold_bad;
        int pulses;
        int busy_seen;
        logic [W-1:0] od;
        logic ob;
        logic ov;
        do_op(8'h22, 8'h11, 1'b0, 1'b0, 3, lat, od, ob, ov, hold_bad);
        checks++;
        if (lat !== LAT) begin
            failures++;
            $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (od !== 8'h11 || ob !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result: got d=%02h bout=%0d ovf=%0d expected d=11 bout=0 ovf=0", od, ob, ov);
        end
        checks++;
        if (hold_bad !== 0) begin
            failures++;
            $display("FAIL ignore_hold: got %0d partial-result cycles expected 0", hold_bad);
        end
        pulses    = 0;
        busy_seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
            if (bus.busy === 1'b1) busy_seen++;
        end
        checks++;
        if (pulses !== 0 || busy_seen !== 0) begin
            failures++;
            $display("FAIL ignore_extra_op: got done=%0d busy=%0d cycles expected 0 0", pulses, busy_seen);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int hold_bad;
        int pulses;
        logic [W-1:0] od;
        logic ob;
        logic ov;
        bus.start = 1'b1;
        bus.a     = 8'h33;
        bus.b     = 8'h11;
        bus.bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before: got busy=%0d expected 1", bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.bout, bus.ovf} !== 5'b10000 || bus.d !== 8'h00) begin
            failures++;
            $display("FAIL abort_async: got rdy/busy/done/bout/ovf=%05b d=%02h expected 10000 d=00",
                     {bus.ready, bus.busy, bus.done, bus.bout, bus.ovf}, bus.d);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", pulses);
        end
        do_op(8'h0A, 8'h0A, 1'b0, 1'b0, 0, lat, od, ob, ov, hold_bad);
        checks++;
        if (lat !== LAT || od !== 8'h00 || ob !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL abort_recover: got lat=%0d d=%02h bout=%0d ovf=%0d expected lat=%0d d=00 bout=0 ovf=0",
                     lat, od, ob, ov, LAT);
        end
    endtask

    task automatic test_random();
        int lat;
        int hold_bad;
        logic [W-1:0] od;
        logic ob;
        logic ov;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rbin;
        logic [W-1:0] ed;
        logic eb;
        logic eo;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 5))
                0:       ra = 8'h00;
                1:       ra = 8'hFF;
                2:       ra = 8'h80;
                3:       ra = 8'h7F;
                default: ra = W'($urandom);
            endcase
            rb   = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
            rbin = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) @(negedge clk);
            end
            ref_sub(ra, rb, rbin, ed, eb, eo);
            do_op(ra, rb, rbin, 1'b1, 0, lat, od, ob, ov, hold_bad);
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, LAT);
            end
            checks++;
            if (od !== ed || ob !== eb || ov !== eo) begin
                failures++;
                $display("FAIL rand%0d_result: a=%02h b=%02h bin=%0d got d=%02h bout=%0d ovf=%0d expected d=%02h bout=%0d ovf=%0d",
                         n, ra, rb, rbin, od, ob, ov, ed, eb, eo);
            end
            checks++;
            if (hold_bad !== 0) begin
                failures++;
                $display("FAIL rand%0d_hold: got %0d partial-result cycles expected 0", n, hold_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
